// File: rtl/gmii_rx_pkg.sv
// rtl/gmii_rx_pkg.sv - shared constants and FSM state type for the GMII receive framer
package gmii_rx_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational CRC-32 advance by one byte, data taken LSB first
module crc32_d8
  import gmii_rx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  // The register is kept bit-reversed relative to the usual reflected form, so
  // a left shift with 0x04C11DB7 is the same CRC and a good frame leaves C704DD7B.
  always_comb begin
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    crc_next = c;
  end

endmodule

// File: rtl/gmii_rx_frame.sv
// rtl/gmii_rx_frame.sv - GMII receive framer: preamble strip, CRC/length check, FCS removal
// Optional destination-address filter enabled by defining MAC_FILTER_EN.
module gmii_rx_frame
  import gmii_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
`ifdef MAC_FILTER_EN
  , parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55
`endif
) (
  input  logic        gmii_rx_clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_sof,
  output logic        m_eof,
  output logic        m_err,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [15:0] MIN_C = 16'(MIN_LEN);
  localparam logic [15:0] MAX_C = 16'(MAX_LEN);

  rx_state_t   state;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [15:0] count;
  logic [31:0] sr;
  logic [7:0]  pending;
  logic        pend_valid;
  logic        emitted;
  logic        frame_bad;
  logic        da_reject;

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (gmii_rxd),
    .crc_next (crc_next)
  );

  assign frame_bad = (crc != CRC_RESIDUE) || (count < MIN_C);

`ifdef MAC_FILTER_EN
  logic       da_local;
  logic       da_bcast;
  logic       local_hit;
  logic       bcast_hit;
  logic [7:0] da_byte;

  always_comb begin
    da_byte = LOCAL_MAC[47:40];
    case (count[2:0])
      3'd1:    da_byte = LOCAL_MAC[39:32];
      3'd2:    da_byte = LOCAL_MAC[31:24];
      3'd3:    da_byte = LOCAL_MAC[23:16];
      3'd4:    da_byte = LOCAL_MAC[15:8];
      3'd5:    da_byte = LOCAL_MAC[7:0];
      default: da_byte = LOCAL_MAC[47:40];
    endcase
  end

  assign local_hit = da_local && (gmii_rxd == da_byte);
  assign bcast_hit = da_bcast && (gmii_rxd == 8'hFF);
  // Decided on DA byte 5, which is exactly when byte 0 would first be emitted.
  assign da_reject = (count == 16'd5) && !(local_hit || bcast_hit);

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      da_local <= 1'b1;
      da_bcast <= 1'b1;
    end else if (state == PREAMBLE) begin
      da_local <= 1'b1;
      da_bcast <= 1'b1;
    end else if (state == DATA && gmii_rx_dv && count < 16'd6) begin
      da_local <= local_hit;
      da_bcast <= bcast_hit;
    end
  end
`else
  assign da_reject = 1'b0;
`endif

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      crc        <= CRC_INIT;
      count      <= 16'd0;
      sr         <= 32'd0;
      pending    <= 8'd0;
      pend_valid <= 1'b0;
      emitted    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= 8'd0;
      m_sof      <= 1'b0;
      m_eof      <= 1'b0;
      m_err      <= 1'b0;
      good_cnt   <= 16'd0;
      bad_cnt    <= 16'd0;
    end else begin
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
      m_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (gmii_rx_dv) state <= (gmii_rxd == PREAMBLE_BYTE) ? PREAMBLE : DROP;
        end
        PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
          end else if (gmii_rxd == SFD_BYTE) begin
            state      <= DATA;
            crc        <= CRC_INIT;
            count      <= 16'd0;
            pend_valid <= 1'b0;
            emitted    <= 1'b0;
          end else if (gmii_rxd != PREAMBLE_BYTE) begin
            state <= DROP;
          end
        end
        DATA: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            if (pend_valid) begin
              m_valid <= 1'b1;
              m_data  <= pending;
              m_sof   <= !emitted;
              m_eof   <= 1'b1;
              m_err   <= frame_bad;
              if (frame_bad) bad_cnt  <= bad_cnt + 16'd1;
              else           good_cnt <= good_cnt + 16'd1;
            end else begin
              bad_cnt <= bad_cnt + 16'd1;
            end
          end else if (count == MAX_C) begin
            state   <= DROP;
            m_valid <= 1'b1;
            m_data  <= pending;
            m_sof   <= !emitted;
            m_eof   <= 1'b1;
            m_err   <= 1'b1;
            bad_cnt <= bad_cnt + 16'd1;
          end else if (da_reject) begin
            state <= DROP;
          end else begin
            crc   <= crc_next;
            count <= count + 16'd1;
            sr    <= {sr[23:0], gmii_rxd};
            // The last four bytes held in sr are the FCS once dv falls.
            if (count >= 16'd4) begin
              pending    <= sr[31:24];
              pend_valid <= 1'b1;
            end
            if (pend_valid) begin
              m_valid <= 1'b1;
              m_data  <= pending;
              m_sof   <= !emitted;
              emitted <= 1'b1;
            end
          end
        end
        DROP: begin
          if (!gmii_rx_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb/tb_gmii_rx_frame.sv - scoreboard bench for gmii_rx_frame
module tb_gmii_rx_frame;

  localparam logic [47:0] LOCAL = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER = 48'h00_11_22_33_44_56;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_sof;
  logic        m_eof;
  logic        m_err;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  gmii_rx_frame dut (
    .gmii_rx_clk (clk),
    .rst_n       (rst_n),
    .gmii_rx_dv  (dv),
    .gmii_rxd    (rxd),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_sof       (m_sof),
    .m_eof       (m_eof),
    .m_err       (m_err),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  frm[$];
  logic [15:0] exp_good = 16'd0;
  logic [15:0] exp_bad = 16'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (exp_q.size() == 0) check("unexpected_beat", 64'(exp_q.size()), 64'd1);
      else                   check("beat", {m_data, m_sof, m_eof, m_err}, exp_q.pop_front());
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    #1;
    dv  = v;
    rxd = d;
  endtask

  task automatic build(input int n, input logic [47:0] da);
    frm.delete();
    for (int i = 0; i < n; i++) begin
      if (i < 6) frm.push_back(da[47-8*i -: 8]);
      else       frm.push_back(8'($urandom));
    end
  endtask

  task automatic add_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frm[i]) begin
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
  endtask

  task automatic expect_beats(input int npay, input int eof_at, input bit err);
    for (int i = 0; i < npay; i++)
      exp_q.push_back({frm[i], i == 0, i == eof_at, (i == eof_at) && err});
  endtask

  task automatic send(input int nbytes, input int gap);
    repeat (7) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < nbytes; i++) drive(1'b1, frm[i]);
    repeat (gap) drive(1'b0, 8'h00);
  endtask

  task automatic settle(input string tag);
    repeat (10) drive(1'b0, 8'h00);
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_good"}, 64'(good_cnt), 64'(exp_good));
    check({tag, "_bad"}, 64'(bad_cnt), 64'(exp_bad));
  endtask

  task automatic good_frame(input string tag, input logic [47:0] da);
    build(60, da);
    add_fcs();
    expect_beats(60, 59, 1'b0);
    send(64, 1);
    exp_good++;
    settle(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {m_valid, m_data, m_sof, m_eof, m_err, good_cnt, bad_cnt}, 64'd0);
    #1 rst_n = 1'b1;

    good_frame("good60", LOCAL);

    build(60, LOCAL);
    add_fcs();
    frm[10] = frm[10] ^ 8'h01;
    expect_beats(60, 59, 1'b1);
    send(64, 1);
    exp_bad++;
    settle("crc_err");

    build(40, LOCAL);
    add_fcs();
    expect_beats(40, 39, 1'b1);
    send(44, 1);
    exp_bad++;
    settle("runt");

    build(1, LOCAL);
    add_fcs();
    expect_beats(1, 0, 1'b1);
    send(5, 1);
    exp_bad++;
    settle("one_byte");

    build(3, LOCAL);
    send(3, 1);
    exp_bad++;
    settle("short");

    repeat (3) drive(1'b1, 8'h55);
    drive(1'b0, 8'h00);
    repeat (3) drive(1'b1, 8'hAA);
    settle("abort_idle");

    build(1600, LOCAL);
    expect_beats(1514, 1513, 1'b1);
    send(1600, 1);
    exp_bad++;
    settle("giant");
    good_frame("after_giant", LOCAL);

    build(60, LOCAL);
    add_fcs();
    expect_beats(60, 59, 1'b0);
    send(64, 1);
    build(60, BCAST);
    add_fcs();
    expect_beats(60, 59, 1'b0);
    send(64, 1);
    exp_good += 16'd2;
    settle("back2back");

    build(60, LOCAL);
    add_fcs();
    for (int i = 0; i < 7; i++) exp_q.push_back({frm[i], i == 0, 1'b0, 1'b0});
    send(12, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    dv = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", {m_valid, m_data, m_sof, m_eof, m_err, good_cnt, bad_cnt}, 64'd0);
    check("mid_reset_drain", 64'(exp_q.size()), 64'd0);
    #1 rst_n = 1'b1;
    exp_good = 16'd0;
    exp_bad  = 16'd0;
    good_frame("after_reset", LOCAL);

`ifdef MAC_FILTER_EN
    good_frame("filter_bcast", BCAST);
    build(60, OTHER);
    add_fcs();
    send(64, 1);
    settle("filter_other");
    good_frame("filter_local", LOCAL);
`else
    good_frame("nofilter_other", OTHER);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
